// File: rtl/deserializer.sv
// deserializer: serial-to-parallel receiver for an LSB-first serial link.
//
// Takes one bit per clk edge where sin_valid=1 and builds N-bit words LSB-first.
// Each finished word is presented on a valid/ready output port. An sof with
// sin_valid=1 restarts framing, so the bit on sin becomes bit 0 of a new word.
// A word that finishes while the output still holds an unconsumed word is
// dropped, and this sets the sticky overrun flag.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset of all state
//   sin        in   serial data bit, LSB of each word first
//   sin_valid  in   qualifies sin (and sof) on this edge
//   sof        in   start of frame: sin is bit 0 of a new word
//   data_out   out  N-bit assembled word, held while out_valid=1
//   out_valid  out  data_out holds an unconsumed word
//   out_ready  in   consumer accepts the word when out_valid=1
//   busy       out  a partial word (1..N-1 bits) is held
//   overrun    out  sticky: a completed word was dropped; cleared only by reset

module deserializer #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         sof,
  output logic [N-1:0] data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         overrun
);

  localparam int unsigned CntW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    sr_q, sr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    data_q, data_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;

  logic [N-1:0]    word;
  logic            complete;
  logic            accept;

  // The word as it stands once the current bit is shifted in.
  assign word   = {sin, sr_q[N-1:1]};
  assign accept = valid_q & out_ready;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    complete  = 1'b0;

    if (sin_valid) begin
      sr_d = word;
      if (sof) begin
        // Resync: drop any partial word silently, this bit is bit 0.
        cnt_d   = CntW'(1);
        state_d = StShift;
      end else begin
        unique case (state_q)
          StIdle: begin
            cnt_d   = CntW'(1);
            state_d = StShift;
          end
          StShift: begin
            if (cnt_q == CntW'(N - 1)) begin
              complete = 1'b1;
              cnt_d    = '0;
              state_d  = StIdle;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
          default: begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        endcase
      end
    end

    if (complete) begin
      // A handshake on the same edge frees the output, so there is no drop.
      if (!valid_q || accept) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == StShift);
  assign overrun   = overrun_q;

endmodule
